// File: rtl/sprite_pkg.sv
// Shared types, constants and wrap-around helpers for the sprite compositor.
package sprite_pkg;

    localparam int unsigned RGB_W   = 12;
    localparam int unsigned COORD_W = 10;

    localparam logic [RGB_W-1:0] TRANS_KEY_DEF = 12'h000;
    localparam logic [RGB_W-1:0] BG_RGB_DEF    = 12'h000;

    // Bit positions inside each sprite's 4-bit move request nibble
    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // (a + b) mod m, assuming a < m and b < m
    function automatic coord_t wrap_add(coord_t a, coord_t b, int unsigned m);
        logic [COORD_W:0] sum;
        logic [COORD_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (COORD_W+1)'(m);
        if (sum >= lim) sum = sum - lim;
        return coord_t'(sum);
    endfunction

    // (a - b) mod m, assuming a < m and b < m
    function automatic coord_t wrap_sub(coord_t a, coord_t b, int unsigned m);
        logic [COORD_W:0] diff;
        if (a >= b) return a - b;
        diff = {1'b0, a} + (COORD_W+1)'(m) - {1'b0, b};
        return coord_t'(diff);
    endfunction

endpackage

// File: rtl/sprite_pos.sv
// Per-sprite wrap-around position register, stepped on each move strobe.
module sprite_pos
    import sprite_pkg::*;
#(
    parameter int unsigned SCR_W  = 320,
    parameter int unsigned SCR_H  = 240,
    parameter int unsigned STEP   = 1,
    parameter int unsigned INIT_X = 0,
    parameter int unsigned INIT_Y = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [3:0] req,
    output coord_t     x,
    output coord_t     y
);

    localparam coord_t STEP_C = coord_t'(STEP);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // Opposite requests on one axis cancel; the other axis still moves
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (move_tick) begin
            if (req[DIR_RIGHT] && !req[DIR_LEFT]) begin
                x_d = wrap_add(x_q, STEP_C, SCR_W);
            end else if (req[DIR_LEFT] && !req[DIR_RIGHT]) begin
                x_d = wrap_sub(x_q, STEP_C, SCR_W);
            end
            if (req[DIR_DOWN] && !req[DIR_UP]) begin
                y_d = wrap_add(y_q, STEP_C, SCR_H);
            end else if (req[DIR_UP] && !req[DIR_DOWN]) begin
                y_d = wrap_sub(y_q, STEP_C, SCR_H);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= coord_t'(INIT_X);
            y_q <= coord_t'(INIT_Y);
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite mover and 3-stage priority pixel compositor.
// Optional frame collision flag enabled by defining SPRITE_COLLIDE_EN.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned      NUM_SPR   = 2,
    parameter int unsigned      SPR_W     = 20,
    parameter int unsigned      SPR_H     = 20,
    parameter int unsigned      SCR_W     = 320,
    parameter int unsigned      SCR_H     = 240,
    parameter int unsigned      STEP      = 1,
    parameter logic [RGB_W-1:0] TRANS_KEY = TRANS_KEY_DEF,
    parameter logic [RGB_W-1:0] BG_RGB    = BG_RGB_DEF,
    parameter int unsigned      ADDR_W    = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        move_tick,
    input  logic [4*NUM_SPR-1:0]        move_req,
    input  logic                        valid,
    input  logic [COORD_W-1:0]          h_cnt,
    input  logic [COORD_W-1:0]          v_cnt,
    output logic [ADDR_W*NUM_SPR-1:0]   rom_addr,
    input  logic [RGB_W*NUM_SPR-1:0]    rom_data,
    output logic [RGB_W-1:0]            rgb,
    output logic                        rgb_valid,
    output logic [COORD_W*NUM_SPR-1:0]  pos_x,
    output logic [COORD_W*NUM_SPR-1:0]  pos_y,
    output logic                        collide
);

    localparam coord_t SPR_W_C = coord_t'(SPR_W);
    localparam coord_t SPR_H_C = coord_t'(SPR_H);

    coord_t spr_x [NUM_SPR];
    coord_t spr_y [NUM_SPR];

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        sprite_pos #(
            .SCR_W  (SCR_W),
            .SCR_H  (SCR_H),
            .STEP   (STEP),
            .INIT_X (i * 2 * SPR_W),
            .INIT_Y (0)
        ) u_pos (
            .clk       (clk),
            .rst       (rst),
            .move_tick (move_tick),
            .req       (move_req[4*i +: 4]),
            .x         (spr_x[i]),
            .y         (spr_y[i])
        );
        assign pos_x[COORD_W*i +: COORD_W] = spr_x[i];
        assign pos_y[COORD_W*i +: COORD_W] = spr_y[i];
    end

    // Stage 0: hit test and ROM address from the current scan position
    logic [NUM_SPR-1:0] hit_s0;
    logic [ADDR_W-1:0]  addr_s0 [NUM_SPR];
    coord_t             dx, dy;

    always_comb begin
        dx = '0;
        dy = '0;
        hit_s0 = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            dx = wrap_sub(h_cnt, spr_x[i], SCR_W);
            dy = wrap_sub(v_cnt, spr_y[i], SCR_H);
            hit_s0[i] = valid && (dx < SPR_W_C) && (dy < SPR_H_C);
            addr_s0[i] = hit_s0[i] ? ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx) : '0;
        end
    end

    logic [NUM_SPR-1:0] hit1_q, hit2_q;
    logic [ADDR_W-1:0]  addr1_q [NUM_SPR];
    logic               valid1_q, valid2_q;
    rgb_t               rgb_q, rgb_d;
    logic               rgb_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit1_q      <= '0;
            hit2_q      <= '0;
            valid1_q    <= 1'b0;
            valid2_q    <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) addr1_q[i] <= '0;
        end else begin
            hit1_q      <= hit_s0;
            valid1_q    <= valid;
            for (int i = 0; i < NUM_SPR; i++) addr1_q[i] <= addr_s0[i];
            hit2_q      <= hit1_q;
            valid2_q    <= valid1_q;
            rgb_q       <= rgb_d;
            rgb_valid_q <= valid2_q;
        end
    end

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_addr
        assign rom_addr[ADDR_W*i +: ADDR_W] = addr1_q[i];
    end

    // Stage 2: ROM data is back; lowest-index opaque sprite wins
    logic [NUM_SPR-1:0] opaque;

    always_comb begin
        opaque = '0;
        rgb_d  = valid2_q ? BG_RGB : '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque[i] = hit2_q[i] && (rom_data[RGB_W*i +: RGB_W] != TRANS_KEY);
        end
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            if (opaque[i]) rgb_d = rom_data[RGB_W*i +: RGB_W];
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

`ifdef SPRITE_COLLIDE_EN
    logic sof0, sof1_q, sof2_q;
    logic multi;
    logic pending_q, collide_q;

    assign sof0  = valid && (h_cnt == '0) && (v_cnt == '0);
    assign multi = |(opaque & (opaque - NUM_SPR'(1)));

    // Frame boundary is judged at stage 2 so it lines up with the opaque flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sof1_q    <= 1'b0;
            sof2_q    <= 1'b0;
            pending_q <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            sof1_q <= sof0;
            sof2_q <= sof1_q;
            if (sof2_q) begin
                collide_q <= pending_q;
                pending_q <= multi;
            end else if (multi) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised and directed self-checking bench for sprite_compositor.
module tb_sprite_compositor;

    localparam int NUM_SPR = 2;
    localparam int SPR_W   = 20;
    localparam int SPR_H   = 20;
    localparam int SCR_W   = 320;
    localparam int SCR_H   = 240;
    localparam int STEP    = 1;
    localparam int ADDR_W  = 17;
    localparam logic [11:0] TRANS_KEY = 12'h000;
    localparam logic [11:0] BG_RGB    = 12'h000;

    logic                        clk, rst, move_tick, valid;
    logic [4*NUM_SPR-1:0]        move_req;
    logic [9:0]                  h_cnt, v_cnt;
    logic [ADDR_W*NUM_SPR-1:0]   rom_addr;
    logic [12*NUM_SPR-1:0]       rom_data;
    logic [11:0]                 rgb;
    logic                        rgb_valid, collide;
    logic [10*NUM_SPR-1:0]       pos_x, pos_y;

    int total = 0;
    int bad   = 0;

    int          rom_mode;
    logic [11:0] const_data [NUM_SPR];
    logic [11:0] rom_q      [NUM_SPR];
    int          mx [NUM_SPR];
    int          my [NUM_SPR];

    typedef struct {
        logic [11:0]               rgb;
        logic                      vld;
        logic [ADDR_W*NUM_SPR-1:0] addr;
    } exp_t;

    sprite_compositor #(
        .NUM_SPR   (NUM_SPR),
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .SCR_W     (SCR_W),
        .SCR_H     (SCR_H),
        .STEP      (STEP),
        .TRANS_KEY (TRANS_KEY),
        .BG_RGB    (BG_RGB),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick),
        .move_req  (move_req),
        .valid     (valid),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rgb       (rgb),
        .rgb_valid (rgb_valid),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .collide   (collide)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Sprite ROM contents: either a per-sprite constant or an address pattern
    function automatic logic [11:0] rom_val(int i, int addr);
        if (rom_mode == 1) return const_data[i];
        if ((addr + i * 3) % 7 == 0) return TRANS_KEY;
        return 12'((addr * 29 + i * 613) % 4095 + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SPR; i++) rom_q[i] <= rom_val(i, int'(rom_addr[i*ADDR_W +: ADDR_W]));
    end

    always_comb begin
        rom_data = '0;
        for (int i = 0; i < NUM_SPR; i++) rom_data[i*12 +: 12] = rom_q[i];
    end

    function automatic void model_reset();
        for (int i = 0; i < NUM_SPR; i++) begin
            mx[i] = i * 2 * SPR_W;
            my[i] = 0;
        end
    endfunction

    function automatic void model_move(logic [4*NUM_SPR-1:0] req);
        for (int i = 0; i < NUM_SPR; i++) begin
            if (req[4*i] && !req[4*i+1]) mx[i] = (mx[i] + STEP) % SCR_W;
            if (req[4*i+1] && !req[4*i]) mx[i] = (mx[i] - STEP + SCR_W) % SCR_W;
            if (req[4*i+2] && !req[4*i+3]) my[i] = (my[i] + STEP) % SCR_H;
            if (req[4*i+3] && !req[4*i+2]) my[i] = (my[i] - STEP + SCR_H) % SCR_H;
        end
    endfunction

    function automatic exp_t model_pixel(int h, int v, bit vld);
        exp_t e;
        bit   won = 1'b0;
        e.vld  = vld;
        e.addr = '0;
        e.rgb  = vld ? BG_RGB : 12'h000;
        for (int i = 0; i < NUM_SPR; i++) begin
            int dx = (h - mx[i] + SCR_W) % SCR_W;
            int dy = (v - my[i] + SCR_H) % SCR_H;
            if (vld && dx < SPR_W && dy < SPR_H) begin
                int a = dy * SPR_W + dx;
                e.addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
                if (!won && rom_val(i, a) != TRANS_KEY) begin
                    won   = 1'b1;
                    e.rgb = rom_val(i, a);
                end
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        move_tick = 1'b0;
        move_req  = '0;
        valid     = 1'b0;
        h_cnt     = '0;
        v_cnt     = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic strobe(input logic [4*NUM_SPR-1:0] req);
        move_req  = req;
        move_tick = 1'b1;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        move_req  = '0;
        model_move(req);
    endtask

    task automatic run_pixel(input int h, input int v, input bit vld,
                             output logic [11:0] o_rgb, output logic o_rv,
                             output logic [ADDR_W*NUM_SPR-1:0] o_addr, output logic o_mid_rv);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vld;
        @(posedge clk); #1;
        o_addr = rom_addr;
        valid  = 1'b0;
        @(posedge clk); #1;
        o_mid_rv = rgb_valid;
        @(posedge clk); #1;
        o_rgb = rgb;
        o_rv  = rgb_valid;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pos_x !== {10'd40, 10'd0}) begin bad++; $display("FAIL reset_pos_x got=%0h want=%0h", pos_x, {10'd40, 10'd0}); end
        total++; if (pos_y !== 20'd0) begin bad++; $display("FAIL reset_pos_y got=%0h want=0", pos_y); end
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%0h want=0", rgb); end
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL reset_rgb_valid got=%0b want=0", rgb_valid); end
        total++; if (collide !== 1'b0) begin bad++; $display("FAIL reset_collide got=%0b want=0", collide); end
        total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr got=%0h want=0", rom_addr); end
    endtask

    task automatic test_move();
        do_reset();
        repeat (5) strobe(8'h01);
        total++; if (pos_x[9:0] !== 10'd5) begin bad++; $display("FAIL move_right got=%0d want=5", pos_x[9:0]); end
        move_req = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        move_req = '0;
        total++; if (pos_x[9:0] !== 10'd5) begin bad++; $display("FAIL move_no_tick got=%0d want=5", pos_x[9:0]); end
        repeat (6) strobe(8'h02);
        total++; if (pos_x[9:0] !== 10'd319) begin bad++; $display("FAIL move_left_wrap got=%0d want=319", pos_x[9:0]); end
        strobe(8'h08);
        total++; if (pos_y[9:0] !== 10'd239) begin bad++; $display("FAIL move_up_wrap got=%0d want=239", pos_y[9:0]); end
        total++; if (pos_x[19:10] !== 10'd40) begin bad++; $display("FAIL move_other_held got=%0d want=40", pos_x[19:10]); end
        do_reset();
        repeat (10) strobe(8'h05);
        total++; if ({pos_x[9:0], pos_y[9:0]} !== {10'd10, 10'd10}) begin bad++; $display("FAIL move_diag got=%0d,%0d want=10,10", pos_x[9:0], pos_y[9:0]); end
        strobe(8'h07);
        total++; if ({pos_x[9:0], pos_y[9:0]} !== {10'd10, 10'd11}) begin bad++; $display("FAIL move_lr_cancel got=%0d,%0d want=10,11", pos_x[9:0], pos_y[9:0]); end
        strobe(8'hAD);
        total++; if ({pos_x[9:0], pos_y[9:0]} !== {10'd11, 10'd11}) begin bad++; $display("FAIL move_ud_cancel got=%0d,%0d want=11,11", pos_x[9:0], pos_y[9:0]); end
        total++; if ({pos_x[19:10], pos_y[19:10]} !== {10'd39, 10'd239}) begin bad++; $display("FAIL move_spr1_diag got=%0d,%0d want=39,239", pos_x[19:10], pos_y[19:10]); end
    endtask

    task automatic test_pixel();
        logic [11:0] r;
        logic        rv, mid;
        logic [ADDR_W*NUM_SPR-1:0] a;
        do_reset();
        rom_mode = 1;
        const_data[0] = 12'hF00;
        const_data[1] = 12'h0AB;
        run_pixel(3, 4, 1'b1, r, rv, a, mid);
        total++; if (a[16:0] !== 17'd83) begin bad++; $display("FAIL pix_addr0 got=%0d want=83", a[16:0]); end
        total++; if (a[33:17] !== 17'd0) begin bad++; $display("FAIL pix_addr1 got=%0d want=0", a[33:17]); end
        total++; if (mid !== 1'b0) begin bad++; $display("FAIL pix_latency got=%0b want=0", mid); end
        total++; if ({r, rv} !== {12'hF00, 1'b1}) begin bad++; $display("FAIL pix_rgb got=%0h/%0b want=f00/1", r, rv); end
        run_pixel(19, 19, 1'b1, r, rv, a, mid);
        total++; if (a[16:0] !== 17'd399 || r !== 12'hF00) begin bad++; $display("FAIL pix_corner got=%0d/%0h want=399/f00", a[16:0], r); end
        run_pixel(20, 0, 1'b1, r, rv, a, mid);
        total++; if (a[16:0] !== 17'd0 || {r, rv} !== {BG_RGB, 1'b1}) begin bad++; $display("FAIL pix_edge_miss got=%0d/%0h/%0b want=0/%0h/1", a[16:0], r, rv, BG_RGB); end
        repeat (5) strobe(8'h02);
        repeat (3) strobe(8'h08);
        run_pixel(2, 1, 1'b1, r, rv, a, mid);
        total++; if (a[16:0] !== 17'd87 || r !== 12'hF00) begin bad++; $display("FAIL pix_wrap got=%0d/%0h want=87/f00", a[16:0], r); end
        run_pixel(2, 17, 1'b1, r, rv, a, mid);
        total++; if (a[16:0] !== 17'd0) begin bad++; $display("FAIL pix_wrap_miss got=%0d want=0", a[16:0]); end
    endtask

    task automatic test_priority();
        logic [11:0] r;
        logic        rv, mid;
        logic [ADDR_W*NUM_SPR-1:0] a;
        do_reset();
        rom_mode = 1;
        repeat (40) strobe(8'h20);
        total++; if (pos_x[19:10] !== 10'd0) begin bad++; $display("FAIL prio_setup got=%0d want=0", pos_x[19:10]); end
        const_data[0] = TRANS_KEY;
        const_data[1] = 12'h0F0;
        run_pixel(5, 5, 1'b1, r, rv, a, mid);
        total++; if (r !== 12'h0F0) begin bad++; $display("FAIL prio_transparent got=%0h want=0f0", r); end
        const_data[0] = 12'h00F;
        run_pixel(5, 5, 1'b1, r, rv, a, mid);
        total++; if (r !== 12'h00F) begin bad++; $display("FAIL prio_low_wins got=%0h want=00f", r); end
`ifndef SPRITE_COLLIDE_EN
        total++; if (collide !== 1'b0) begin bad++; $display("FAIL prio_collide_tied got=%0b want=0", collide); end
`endif
        run_pixel(100, 100, 1'b1, r, rv, a, mid);
        total++; if ({r, rv} !== {BG_RGB, 1'b1}) begin bad++; $display("FAIL prio_bg got=%0h/%0b want=%0h/1", r, rv, BG_RGB); end
        run_pixel(5, 5, 1'b0, r, rv, a, mid);
        total++; if ({r, rv} !== 13'd0 || a !== '0) begin bad++; $display("FAIL prio_invalid got=%0h/%0b/%0h want=0/0/0", r, rv, a); end
    endtask

`ifdef SPRITE_COLLIDE_EN
    task automatic test_collide();
        logic [11:0] r;
        logic        rv, mid;
        logic [ADDR_W*NUM_SPR-1:0] a;
        do_reset();
        rom_mode = 1;
        const_data[0] = 12'hF00;
        const_data[1] = 12'h0F0;
        repeat (40) strobe(8'h20);
        run_pixel(0, 0, 1'b1, r, rv, a, mid);
        total++; if (collide !== 1'b0) begin bad++; $display("FAIL coll_frame_k got=%0b want=0", collide); end
        repeat (40) strobe(8'h10);
        run_pixel(0, 0, 1'b1, r, rv, a, mid);
        total++; if (collide !== 1'b1) begin bad++; $display("FAIL coll_frame_k1 got=%0b want=1", collide); end
        run_pixel(5, 5, 1'b1, r, rv, a, mid);
        total++; if (collide !== 1'b1) begin bad++; $display("FAIL coll_hold got=%0b want=1", collide); end
        run_pixel(0, 0, 1'b1, r, rv, a, mid);
        total++; if (collide !== 1'b0) begin bad++; $display("FAIL coll_frame_k2 got=%0b want=0", collide); end
    endtask
`endif

    task automatic test_random();
        exp_t                 q[$];
        exp_t                 e;
        logic [4*NUM_SPR-1:0] req;
        logic [10*NUM_SPR-1:0] ex, ey;
        bit                   tick, vld;
        int                   h, v, k;
        do_reset();
        rom_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            k = int'($urandom_range(0, NUM_SPR - 1));
            if ($urandom % 4 != 0) begin
                h = (mx[k] + int'($urandom_range(0, SPR_W + 1)) + SCR_W - 1) % SCR_W;
                v = (my[k] + int'($urandom_range(0, SPR_H + 1)) + SCR_H - 1) % SCR_H;
            end else begin
                h = int'($urandom_range(0, SCR_W - 1));
                v = int'($urandom_range(0, SCR_H - 1));
            end
            vld  = ($urandom % 8 != 0);
            tick = ($urandom % 4 == 0);
            req  = (4*NUM_SPR)'($urandom);
            q.push_back(model_pixel(h, v, vld));
            h_cnt = 10'(h);
            v_cnt = 10'(v);
            valid = vld;
            move_tick = tick;
            move_req  = req;
            @(posedge clk); #1;
            if (tick) model_move(req);
            for (int i = 0; i < NUM_SPR; i++) begin
                ex[10*i +: 10] = 10'(mx[i]);
                ey[10*i +: 10] = 10'(my[i]);
            end
            total++; if ({pos_x, pos_y} !== {ex, ey}) begin bad++; $display("FAIL rnd_pos got=%0h/%0h want=%0h/%0h", pos_x, pos_y, ex, ey); end
            total++; if (rom_addr !== q[$].addr) begin bad++; $display("FAIL rnd_addr got=%0h want=%0h", rom_addr, q[$].addr); end
            if (q.size() == 3) begin
                e = q.pop_front();
                total++; if ({rgb, rgb_valid} !== {e.rgb, e.vld}) begin bad++; $display("FAIL rnd_rgb got=%0h/%0b want=%0h/%0b", rgb, rgb_valid, e.rgb, e.vld); end
            end
        end
        valid = 1'b0;
        move_tick = 1'b0;
        move_req = '0;
        while (q.size() > 0) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total++; if ({rgb, rgb_valid} !== {e.rgb, e.vld}) begin bad++; $display("FAIL rnd_drain got=%0h/%0b want=%0h/%0b", rgb, rgb_valid, e.rgb, e.vld); end
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        rom_mode = 0;
        repeat (3) strobe(8'h45);
        h_cnt = 10'd5;
        v_cnt = 10'd6;
        valid = 1'b1;
        repeat (4) @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        total++; if ({pos_x, pos_y} !== {10'd40, 10'd0, 20'd0}) begin bad++; $display("FAIL mid_rst_pos got=%0h/%0h want=a000/0", pos_x, pos_y); end
        total++; if ({rgb, rgb_valid} !== 13'd0 || rom_addr !== '0) begin bad++; $display("FAIL mid_rst_out got=%0h/%0b/%0h want=0/0/0", rgb, rgb_valid, rom_addr); end
        h_cnt = 10'd3;
        v_cnt = 10'd4;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        e = model_pixel(3, 4, 1'b1);
        #1;
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL mid_rel0 got=%0b want=0", rgb_valid); end
        @(posedge clk); #1;
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL mid_rel1 got=%0b want=0", rgb_valid); end
        @(posedge clk); #1;
        total++; if (rgb_valid !== 1'b0) begin bad++; $display("FAIL mid_rel2 got=%0b want=0", rgb_valid); end
        @(posedge clk); #1;
        total++; if ({rgb, rgb_valid} !== {e.rgb, 1'b1}) begin bad++; $display("FAIL mid_rel3 got=%0h/%0b want=%0h/1", rgb, rgb_valid, e.rgb); end
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        move_tick = 1'b0;
        move_req = '0;
        valid = 1'b0;
        h_cnt = '0;
        v_cnt = '0;
        rom_mode = 0;
        for (int i = 0; i < NUM_SPR; i++) const_data[i] = 12'h000;
        test_reset();
        test_move();
        test_pixel();
        test_priority();
`ifdef SPRITE_COLLIDE_EN
        test_collide();
`endif
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

N-sprite mover and pixel compositor for the 320×240 display path, generalising the two hard-wired sprites into a parametrised engine. Each sprite owns a wrap-around position register driven by per-sprite direction requests on a move strobe; the block computes each sprite's ROM address from the down-scaled scan counters and merges the sprite ROM outputs by fixed priority with a transparency key and background colour. It sits between the scan counters and VGA colour pins, feeding external per-sprite block ROMs.

## Interface
- NUM_SPR, 2: sprite count (1–8)
- SPR_W, 20: sprite width in pixels
- SPR_H, 20: sprite height in pixels
- SCR_W, 320: logical screen width
- SCR_H, 240: logical screen height
- STEP, 1: pixels moved per move strobe (1 ≤ STEP < min(SCR_W, SCR_H))
- TRANS_KEY, 12'h000: ROM colour treated as transparent
- BG_RGB, 12'h000: colour where no opaque sprite pixel exists
- ADDR_W, 17: ROM address width
- Constraint: NUM_SPR·2·SPR_W ≤ SCR_W.

- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-low reset
- move_tick  in  1  one-cycle move strobe
- move_req  in  4·NUM_SPR  per sprite {up,down,left,right}, sprite i at [4i+3:4i]
- valid  in  1  scan position inside active area
- h_cnt  in  10  logical column (0..SCR_W-1)
- v_cnt  in  10  logical row (0..SCR_H-1)
- rom_addr  out  ADDR_W·NUM_SPR  per-sprite ROM address
- rom_data  in  12·NUM_SPR  per-sprite ROM data, one-cycle read latency
- rgb  out  12  composited colour {R,G,B}
- rgb_valid  out  1  rgb corresponds to an active pixel
- pos_x  out  10·NUM_SPR  sprite left column
- pos_y  out  10·NUM_SPR  sprite top row
- collide  out  1  collision flag (SPRITE_COLLIDE_EN only; tied 0 otherwise)

## Operation
- Reset: pos_x[i] = i·2·SPR_W, pos_y[i] = 0; rgb = 0, rgb_valid = 0, rom_addr = 0, collide = 0, all pipeline registers 0.
- Movement on cycles with move_tick = 1 only; move_req sampled that cycle, no latching between strobes.
- right: x ← x+STEP, minus SCR_W if result ≥ SCR_W; left: x ← x−STEP, plus SCR_W if x < STEP. Same for down/up on y with SCR_H.
- Opposite requests together (left+right or up+down): that axis holds; other axis still moves. Diagonal moves both axes in the same strobe.
- Hit test per sprite: dx = (h_cnt − x) mod SCR_W, dy = (v_cnt − y) mod SCR_H; hit when valid and dx < SPR_W and dy < SPR_H. Sprites wrap across screen edges.
- rom_addr[i] = dy·SPR_W + dx on hit, 0 otherwise.
- Opaque = hit and rom_data ≠ TRANS_KEY. Lowest-index opaque sprite wins; none opaque → BG_RGB. Invalid pixel → rgb = 0.
- Position updates take effect for the next pixel entering stage 1; mid-frame tearing is allowed.

## Timing
- Stage 1 (cycle n+1): hit flags, dx/dy, rom_addr registered from h_cnt/v_cnt/valid sampled at n.
- Stage 2 (n+2): rom_data valid; hit flags delayed one cycle alongside.
- Stage 3 (n+3): rgb, rgb_valid registered. Total latency 3 cycles; caller delays hsync/vsync by 3.
- pos_x/pos_y update the cycle after move_tick.
- Reset asserted mid-frame: all state returns to reset values immediately; first output after release is rgb_valid = 0 for 3 cycles.

## Configuration
- SPRITE_COLLIDE_EN defined: a pending bit sets whenever ≥2 sprites are opaque on the same stage-2 pixel. At the first valid pixel of a frame (h_cnt = 0, v_cnt = 0, valid = 1) collide ← pending, pending ← 0 (a collision on that same pixel counts for the new frame). collide holds for one full frame.
- Not defined: no pending logic; collide tied 0.

## Structure
- Package sprite_pkg: RGB width (12), TRANS_KEY/BG_RGB defaults, direction bit indices (UP=3, DOWN=2, LEFT=1, RIGHT=0), coordinate width (10).
- Sub-module sprite_pos: one per sprite via generate; holds x/y registers, wrap arithmetic, move strobe handling.
- Top holds hit pipeline, priority mux, collision logic.

## Test plan
- Reset with NUM_SPR = 2 → pos_x = {40, 0}, pos_y = {0, 0}, rgb = 0, collide = 0.
- Sprite 0 right held for 5 strobes → pos_x[0] = 5; left from x = 0 with STEP = 1 → x = 319; up from y = 0 → y = 239.
- left+right+down on one strobe at (10,10) → (10,11).
- Sprite 0 at (0,0) ROM constant 12'hF00, scan h = 3, v = 4 at cycle n → rom_addr[0] = 83 at n+1, rgb = 12'hF00, rgb_valid = 1 at n+3.
- Sprites 0 and 1 overlapping, sprite 0 data = TRANS_KEY, sprite 1 = 12'h0F0 → rgb = 12'h0F0; sprite 0 = 12'h00F → 12'h00F; neither hit → BG_RGB.
- SPRITE_COLLIDE_EN: overlapping opaque sprites in frame k → collide = 1 from first pixel of frame k+1; separated in frame k+1 → collide = 0 from frame k+2.
